// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared state, opcode/funct and control-field encodings for multi_cycle_ctrl
package ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        EXECUTE   = 4'd7,
        R_WB      = 4'd8,
        I_EXEC    = 4'd9,
        I_WB      = 4'd10,
        BRANCH    = 4'd11,
        JUMP      = 4'd12,
        TRAP      = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b100,
        ALU_LUI = 3'b101
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        EXT_ZERO  = 2'b00,
        EXT_SIGN  = 2'b01,
        EXT_UPPER = 2'b10
    } ext_op_t;

    typedef enum logic [1:0] {
        SRCB_REG     = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } src_b_t;

    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10
    } pc_src_t;

    // Dispatch target out of DECODE; anything not in the supported ISA subset traps.
    function automatic state_t dispatch(input logic [5:0] op);
        case (op)
            OP_RTYPE:              return EXECUTE;
            OP_LW, OP_SW:          return MEM_ADDR;
            OP_BEQ:                return BRANCH;
            OP_J:                  return JUMP;
            OP_ADDI, OP_ORI,
            OP_LUI:                return I_EXEC;
            default:               return TRAP;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - combinational R-type funct to Aluctrl mapping with unknown-funct flag
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output alu_ctrl_t  alu_op,
    output logic       unknown
);

    always_comb begin
        alu_op  = ALU_ADD;
        unknown = 1'b0;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            default: unknown = 1'b1;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - multi-cycle MIPS-subset control FSM; MULTI_CYCLE_CTRL_PERF_EN adds instr_cnt
module multi_cycle_ctrl
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  OpCode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic [1:0]  PCSource,
    output logic        IorD,
    output logic        IRWrite,
    output logic        MemR,
    output logic        MemW,
    output logic        Mem2R,
    output logic        RegW,
    output logic        RegDst,
    output logic        AluSrcA,
    output logic [1:0]  AluSrcB,
    output logic [1:0]  ExtOp,
    output logic [2:0]  Aluctrl,
    output logic        illegal,
`ifdef MULTI_CYCLE_CTRL_PERF_EN
    output logic [31:0] instr_cnt,
`endif
    output logic [3:0]  state
);

    state_t     cur;
    logic [5:0] op_q;
    logic [5:0] fn_q;
    alu_ctrl_t  r_alu;
    logic       fn_bad;

    alu_decoder u_alu_decoder (
        .funct   (fn_q),
        .alu_op  (r_alu),
        .unknown (fn_bad)
    );

    // Dispatch in DECODE looks at the live opcode; later states use the latched copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur  <= IDLE;
            op_q <= 6'd0;
            fn_q <= 6'd0;
        end else begin
            case (cur)
                IDLE:      cur <= FETCH;
                FETCH:     if (mem_ready) cur <= DECODE;
                DECODE: begin
                    op_q <= OpCode;
                    fn_q <= funct;
                    cur  <= dispatch(OpCode);
                end
                MEM_ADDR:  cur <= (op_q == OP_SW) ? MEM_WRITE : MEM_READ;
                MEM_READ:  if (mem_ready) cur <= MEM_WB;
                MEM_WRITE: if (mem_ready) cur <= FETCH;
                MEM_WB:    cur <= FETCH;
                EXECUTE:   cur <= fn_bad ? TRAP : R_WB;
                R_WB:      cur <= FETCH;
                I_EXEC:    cur <= I_WB;
                I_WB:      cur <= FETCH;
                BRANCH:    cur <= FETCH;
                JUMP:      cur <= FETCH;
                TRAP:      cur <= TRAP;
                default:   cur <= IDLE;
            endcase
        end
    end

`ifdef MULTI_CYCLE_CTRL_PERF_EN
    logic retire;

    always_comb begin
        retire = 1'b0;
        case (cur)
            R_WB, MEM_WB, BRANCH, JUMP, I_WB: retire = 1'b1;
            MEM_WRITE:                        retire = mem_ready;
            default:                          retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_cnt <= 32'd0;
        end else if (retire) begin
            instr_cnt <= instr_cnt + 32'd1;
        end
    end
`endif

    always_comb begin
        PCWrite  = 1'b0;
        PCSource = PC_ALU;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        MemR     = 1'b0;
        MemW     = 1'b0;
        Mem2R    = 1'b0;
        RegW     = 1'b0;
        RegDst   = 1'b0;
        AluSrcA  = 1'b0;
        AluSrcB  = SRCB_REG;
        ExtOp    = EXT_ZERO;
        Aluctrl  = ALU_ADD;
        illegal  = 1'b0;
        case (cur)
            FETCH: begin
                MemR     = 1'b1;
                IRWrite  = 1'b1;
                PCWrite  = 1'b1;
                PCSource = PC_ALU;
                AluSrcB  = SRCB_FOUR;
                Aluctrl  = ALU_ADD;
            end
            DECODE: begin
                AluSrcB = SRCB_IMM_SH2;
                ExtOp   = EXT_SIGN;
                Aluctrl = ALU_ADD;
            end
            MEM_ADDR: begin
                AluSrcA = 1'b1;
                AluSrcB = SRCB_IMM;
                ExtOp   = EXT_SIGN;
                Aluctrl = ALU_ADD;
            end
            MEM_READ: begin
                IorD = 1'b1;
                MemR = 1'b1;
            end
            MEM_WRITE: begin
                IorD = 1'b1;
                MemW = 1'b1;
            end
            MEM_WB: begin
                RegW  = 1'b1;
                Mem2R = 1'b1;
            end
            EXECUTE: begin
                AluSrcA = 1'b1;
                AluSrcB = SRCB_REG;
                Aluctrl = r_alu;
            end
            R_WB: begin
                RegW   = 1'b1;
                RegDst = 1'b1;
            end
            I_EXEC: begin
                AluSrcA = 1'b1;
                AluSrcB = SRCB_IMM;
                case (op_q)
                    OP_ADDI: begin ExtOp = EXT_SIGN;  Aluctrl = ALU_ADD; end
                    OP_ORI:  begin ExtOp = EXT_ZERO;  Aluctrl = ALU_OR;  end
                    OP_LUI:  begin ExtOp = EXT_UPPER; Aluctrl = ALU_LUI; end
                    default: begin ExtOp = EXT_ZERO;  Aluctrl = ALU_ADD; end
                endcase
            end
            I_WB: begin
                RegW = 1'b1;
            end
            BRANCH: begin
                AluSrcA  = 1'b1;
                AluSrcB  = SRCB_REG;
                Aluctrl  = ALU_SUB;
                PCSource = PC_ALUOUT;
                PCWrite  = zero;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PC_JUMP;
            end
            TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                illegal = 1'b0;
            end
        endcase
    end

    assign state = cur;

endmodule
